// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-word layout,
// opcodes and the bubble value loaded on flush, load-use and reset.
package id_ex_stage_pkg;

  localparam int CTRL_W          = 9;
  localparam int CTRL_WE         = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_ALU_OP_MSB = 3;
  localparam int CTRL_ALU_OP_LSB = 0;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       imm;
    logic [4:0]        ra;
    logic [4:0]        rb;
    logic [4:0]        rd;
    logic [5:0]        op;
    logic [5:0]        func;
    logic [CTRL_W-1:0] ctrl;
  } ex_reg_t;

  localparam ex_reg_t EX_BUBBLE = '0;

  // FLUSH and BUBBLE load the same value but are kept apart for the counters
  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_FLUSH
  } ex_upd_e;

  function automatic logic rd_hits(input logic [4:0] rd, input logic [4:0] ra,
                                   input logic [4:0] rb);
    return (rd != 5'd0) && ((rd == ra) || (rd == rb));
  endfunction

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Operand forwarding for the EX stage: selects MEM/WB bypass data over the
// registered operands and applies the immediate for the ALU B input.
module id_ex_fwd_mux (
  input  logic [31:0] ex_a_i,
  input  logic [31:0] ex_b_i,
  input  logic [31:0] ex_imm_i,
  input  logic        alu_src_i,
  input  logic        a_mem_i,
  input  logic        a_wb_i,
  input  logic        b_mem_i,
  input  logic        b_wb_i,
  input  logic [31:0] mem_fwd_i,
  input  logic [31:0] wb_fwd_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [31:0] store_data_o
);

  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;

  // MEM result is younger than WB data, so it wins when both are selected
  assign w_fwd_a = a_mem_i ? mem_fwd_i : (a_wb_i ? wb_fwd_i : ex_a_i);
  assign w_fwd_b = b_mem_i ? mem_fwd_i : (b_wb_i ? wb_fwd_i : ex_b_i);

  assign alu_a_o      = w_fwd_a;
  assign alu_b_o      = alu_src_i ? ex_imm_i : w_fwd_b;
  assign store_data_o = w_fwd_b;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and operand forwarding.
// Define ID_EX_PERF_CNT_EN to add bubble/hold performance counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [31:0]       id_pc_i,
  input  logic [31:0]       id_a_i,
  input  logic [31:0]       id_b_i,
  input  logic [31:0]       id_imm_i,
  input  logic [4:0]        id_ra_i,
  input  logic [4:0]        id_rb_i,
  input  logic [4:0]        id_rd_i,
  input  logic [5:0]        id_op_i,
  input  logic [5:0]        id_func_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              a_mem_i,
  input  logic              a_wb_i,
  input  logic              b_mem_i,
  input  logic              b_wb_i,
  input  logic [31:0]       mem_fwd_i,
  input  logic [31:0]       wb_fwd_i,
  output logic              ex_valid_o,
  output logic [31:0]       ex_pc_o,
  output logic [4:0]        ex_ra_o,
  output logic [4:0]        ex_rb_o,
  output logic [4:0]        ex_rd_o,
  output logic [5:0]        ex_op_o,
  output logic [5:0]        ex_func_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [31:0]       alu_a_o,
  output logic [31:0]       alu_b_o,
  output logic [31:0]       store_data_o,
  output logic              load_use_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       hold_cnt_o
`endif
);

  ex_reg_t r_ex;
  ex_reg_t w_id;
  ex_upd_e w_upd;
  logic    w_load_use;

  assign w_id = '{valid: id_valid_i, pc: id_pc_i, a: id_a_i, b: id_b_i,
                  imm: id_imm_i, ra: id_ra_i, rb: id_rb_i, rd: id_rd_i,
                  op: id_op_i, func: id_func_i, ctrl: id_ctrl_i};

  assign w_load_use = r_ex.valid && r_ex.ctrl[CTRL_MEM_READ] && id_valid_i &&
                      rd_hits(r_ex.rd, id_ra_i, id_rb_i);

  // A stall outranks the load-use bubble, so the load stays in EX and the
  // hazard keeps being reported until the stall is released
  always_comb begin
    w_upd = UPD_LOAD;
    if (flush_i)         w_upd = UPD_FLUSH;
    else if (stall_i)    w_upd = UPD_HOLD;
    else if (w_load_use) w_upd = UPD_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex <= EX_BUBBLE;
    end else begin
      case (w_upd)
        UPD_FLUSH, UPD_BUBBLE: r_ex <= EX_BUBBLE;
        UPD_HOLD:              r_ex <= r_ex;
        default:               r_ex <= w_id;
      endcase
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_hold_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= 32'd0;
      r_hold_cnt   <= 32'd0;
    end else begin
      if (w_upd == UPD_BUBBLE) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_upd == UPD_HOLD)   r_hold_cnt   <= r_hold_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
  assign hold_cnt_o   = r_hold_cnt;
`endif

  assign ex_valid_o = r_ex.valid;
  assign ex_pc_o    = r_ex.pc;
  assign ex_ra_o    = r_ex.ra;
  assign ex_rb_o    = r_ex.rb;
  assign ex_rd_o    = r_ex.rd;
  assign ex_op_o    = r_ex.op;
  assign ex_func_o  = r_ex.func;
  assign ex_ctrl_o  = r_ex.ctrl;
  assign load_use_o = w_load_use;

  id_ex_fwd_mux u_fwd (
    .ex_a_i      (r_ex.a),
    .ex_b_i      (r_ex.b),
    .ex_imm_i    (r_ex.imm),
    .alu_src_i   (r_ex.ctrl[CTRL_ALU_SRC]),
    .a_mem_i     (a_mem_i),
    .a_wb_i      (a_wb_i),
    .b_mem_i     (b_mem_i),
    .b_wb_i      (b_wb_i),
    .mem_fwd_i   (mem_fwd_i),
    .wb_fwd_i    (wb_fwd_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .store_data_o(store_data_o)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected EX state
// into a queue, a negedge monitor pops and compares.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, id_valid_i;
  logic [31:0] id_pc_i, id_a_i, id_b_i, id_imm_i;
  logic [4:0]  id_ra_i, id_rb_i, id_rd_i;
  logic [5:0]  id_op_i, id_func_i;
  logic [8:0]  id_ctrl_i;
  logic        a_mem_i, a_wb_i, b_mem_i, b_wb_i;
  logic [31:0] mem_fwd_i, wb_fwd_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [4:0]  ex_ra_o, ex_rb_o, ex_rd_o;
  logic [5:0]  ex_op_o, ex_func_o;
  logic [8:0]  ex_ctrl_o;
  logic [31:0] alu_a_o, alu_b_o, store_data_o;
  logic        load_use_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_o, hold_cnt_o;
`endif

  localparam logic [8:0] C_LW  = 9'h1B0;
  localparam logic [8:0] C_ADD = 9'h102;
  localparam logic [8:0] C_SW  = 9'h050;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [8:0]  ctrl;
    logic        loadUse;
    logic        chkFwd;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [31:0] store;
    logic [31:0] bubbleCnt;
    logic [31:0] holdCnt;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_a_i(id_a_i),
    .id_b_i(id_b_i), .id_imm_i(id_imm_i), .id_ra_i(id_ra_i),
    .id_rb_i(id_rb_i), .id_rd_i(id_rd_i), .id_op_i(id_op_i),
    .id_func_i(id_func_i), .id_ctrl_i(id_ctrl_i), .a_mem_i(a_mem_i),
    .a_wb_i(a_wb_i), .b_mem_i(b_mem_i), .b_wb_i(b_wb_i),
    .mem_fwd_i(mem_fwd_i), .wb_fwd_i(wb_fwd_i), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .ex_ra_o(ex_ra_o), .ex_rb_o(ex_rb_o),
    .ex_rd_o(ex_rd_o), .ex_op_o(ex_op_o), .ex_func_o(ex_func_o),
    .ex_ctrl_o(ex_ctrl_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .store_data_o(store_data_o), .load_use_o(load_use_o)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp({e.name, ".valid"}, 32'(ex_valid_o), 32'(e.valid));
    cmp({e.name, ".pc"}, ex_pc_o, e.pc);
    cmp({e.name, ".rd"}, 32'(ex_rd_o), 32'(e.rd));
    cmp({e.name, ".op"}, 32'(ex_op_o), 32'(e.op));
    cmp({e.name, ".ctrl"}, 32'(ex_ctrl_o), 32'(e.ctrl));
    cmp({e.name, ".load_use"}, 32'(load_use_o), 32'(e.loadUse));
    if (e.chkFwd) begin
      cmp({e.name, ".alu_a"}, alu_a_o, e.aluA);
      cmp({e.name, ".alu_b"}, alu_b_o, e.aluB);
      cmp({e.name, ".store"}, store_data_o, e.store);
    end
`ifdef ID_EX_PERF_CNT_EN
    cmp({e.name, ".bubble_cnt"}, bubble_cnt_o, e.bubbleCnt);
    cmp({e.name, ".hold_cnt"}, hold_cnt_o, e.holdCnt);
`endif
  endtask

  // Monitor: one expectation per negedge, independent of stimulus
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  task automatic pushExp(input string name, input logic v, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [5:0] op,
                         input logic [8:0] ctrl, input logic lu,
                         input logic chkFwd, input logic [31:0] aa,
                         input logic [31:0] ab, input logic [31:0] st,
                         input logic [31:0] bc, input logic [31:0] hc);
    exp_t e;
    e.name = name; e.valid = v; e.pc = pc; e.rd = rd; e.op = op;
    e.ctrl = ctrl; e.loadUse = lu; e.chkFwd = chkFwd; e.aluA = aa;
    e.aluB = ab; e.store = st; e.bubbleCnt = bc; e.holdCnt = hc;
    expQ.push_back(e);
  endtask

  task automatic setId(input logic v, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rd, input logic [5:0] op,
                       input logic [5:0] func, input logic [8:0] ctrl);
    id_valid_i = v; id_pc_i = pc; id_a_i = a; id_b_i = b; id_imm_i = imm;
    id_ra_i = ra; id_rb_i = rb; id_rd_i = rd; id_op_i = op;
    id_func_i = func; id_ctrl_i = ctrl;
  endtask

  task automatic setFwd(input logic am, input logic aw, input logic bm,
                        input logic bw, input logic [31:0] mf,
                        input logic [31:0] wf);
    a_mem_i = am; a_wb_i = aw; b_mem_i = bm; b_wb_i = bw;
    mem_fwd_i = mf; wb_fwd_i = wf;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    setId(1'b1, 32'hDEAD, 32'h1, 32'h2, 32'h3, 5'd5, 5'd5, 5'd5, 6'h23, 6'h0, C_LW);
    setFwd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus();
    applyStimulus();

    // C0: leave reset, present lw r5
    rst_n = 1'b1;
    setId(1'b1, 32'h100, 32'h1000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd5, 6'h23, 6'h0, C_LW);
    pushExp("reset", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus();
    // C1: lw in EX, dependent add in ID
    setId(1'b1, 32'h104, 32'h7, 32'h3, 32'h0, 5'd5, 5'd6, 5'd7, 6'h0, 6'h20, C_ADD);
    pushExp("lw_in_ex", 1, 32'h100, 5, 6'h23, C_LW, 1, 1, 32'h1000, 32'h4, 32'h0, 0, 0);
    applyStimulus();
    // C2: load-use bubble
    pushExp("lu_bubble", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus();
    // C3: add in EX, both A selects -> MEM wins; stall to keep add
    setId(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setFwd(1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22);
    stall_i = 1'b1;
    pushExp("fwd_a_mem", 1, 32'h104, 7, 6'h0, C_ADD, 0, 1, 32'h11, 32'h3, 32'h3, 1, 0);
    applyStimulus();
    // C4: add held, WB only
    stall_i = 1'b0;
    setFwd(1'b0, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22);
    setId(1'b1, 32'h108, 32'h50, 32'h60, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 6'h2b, 6'h0, C_SW);
    pushExp("fwd_a_wb", 1, 32'h104, 7, 6'h0, C_ADD, 0, 1, 32'h22, 32'h3, 32'h3, 1, 1);
    applyStimulus();
    // C5: sw in EX, immediate vs forwarded store data; then flush+stall
    setFwd(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    setId(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush_i = 1'b1; stall_i = 1'b1;
    pushExp("imm_store", 1, 32'h108, 0, 6'h2b, C_SW, 0, 1, 32'h50, 32'hFFFFFFFC, 32'h40, 1, 1);
    applyStimulus();
    // C6: flush beats stall
    flush_i = 1'b0; stall_i = 1'b0;
    setFwd(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    setId(1'b1, 32'h200, 32'h300, 32'h0, 32'h8, 5'd3, 5'd0, 5'd9, 6'h23, 6'h0, C_LW);
    pushExp("flush_stall", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    applyStimulus();
    // C7: lw r9 in EX, add uses r9 on B, stall collides
    setId(1'b1, 32'h204, 32'h1, 32'h2, 32'h0, 5'd1, 5'd9, 5'd10, 6'h0, 6'h20, C_ADD);
    stall_i = 1'b1;
    pushExp("lu_rb", 1, 32'h200, 9, 6'h23, C_LW, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus();
    pushExp("hold1", 1, 32'h200, 9, 6'h23, C_LW, 1, 0, 0, 0, 0, 1, 2);
    applyStimulus();
    pushExp("hold2", 1, 32'h200, 9, 6'h23, C_LW, 1, 0, 0, 0, 0, 1, 3);
    applyStimulus();
    stall_i = 1'b0;
    pushExp("hold3", 1, 32'h200, 9, 6'h23, C_LW, 1, 0, 0, 0, 0, 1, 4);
    applyStimulus();
    // C11: bubble only after stall drops
    pushExp("late_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4);
    applyStimulus();
    // C12: add enters EX; present lw r0
    setId(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 6'h23, 6'h0, C_LW);
    pushExp("add_after", 1, 32'h204, 10, 6'h0, C_ADD, 0, 0, 0, 0, 0, 2, 4);
    applyStimulus();
    // C13: lw r0 never causes a hazard
    setId(1'b1, 32'h304, 32'h5, 32'h6, 32'h0, 5'd0, 5'd0, 5'd4, 6'h0, 6'h20, C_ADD);
    pushExp("lw_rd0", 1, 32'h300, 0, 6'h23, C_LW, 0, 0, 0, 0, 0, 2, 4);
    applyStimulus();
    setId(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd12, 6'h23, 6'h0, C_LW);
    pushExp("add_r0", 1, 32'h304, 4, 6'h0, C_ADD, 0, 0, 0, 0, 0, 2, 4);
    applyStimulus();
    // C15: lw r12 with dependent add, stall
    setId(1'b1, 32'h404, 32'hA, 32'hB, 32'h0, 5'd12, 5'd0, 5'd13, 6'h0, 6'h20, C_ADD);
    stall_i = 1'b1;
    pushExp("lu_pre_rst", 1, 32'h400, 12, 6'h23, C_LW, 1, 0, 0, 0, 0, 2, 4);
    applyStimulus();
    // C16: reset mid-stall
    rst_n = 1'b0;
    pushExp("stall_pre_rst", 1, 32'h400, 12, 6'h23, C_LW, 1, 0, 0, 0, 0, 2, 5);
    applyStimulus();
    rst_n = 1'b1; stall_i = 1'b0;
    pushExp("mid_stall_rst", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus();
    pushExp("resume", 1, 32'h404, 13, 6'h0, C_ADD, 0, 1, 32'hA, 32'hB, 32'hB, 0, 0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
